// File: rtl/elevator_door_ctrl.sv
// Timed elevator door controller: open-hold / stroke timers, reversal on obstruction or call,
// close-button shortcut, motion interlock in CLOSED and nudge mode after repeated reopenings.
module elevator_door_ctrl #(
  parameter int HOLD_CYC   = 8,
  parameter int TRAVEL_CYC = 4,
  parameter int MAX_REOPEN = 3,
  parameter int CNT_W      = 8,
  parameter int RC_W       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       open_req,
  input  logic       close_req,
  input  logic       obstruct,
  input  logic       alarm,
  input  logic       moving,
  output logic       door_open,
  output logic       door_closed,
  output logic       motor_open,
  output logic       motor_close,
  output logic       nudge,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_OPEN    = 2'd0,
    S_CLOSING = 2'd1,
    S_CLOSED  = 2'd2,
    S_OPENING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LD  = CNT_W'(TRAVEL_CYC - 1);
  localparam logic [RC_W-1:0]  REOPEN_MAX = RC_W'(MAX_REOPEN);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [RC_W-1:0]   reopen_cnt_q, reopen_cnt_d;
  logic              nudge_q, nudge_d;
  logic              expire;

  assign expire = (timer_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_OPEN;
      timer_q      <= HOLD_LD;
      reopen_cnt_q <= '0;
      nudge_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      reopen_cnt_q <= reopen_cnt_d;
      nudge_q      <= nudge_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = expire ? timer_q : timer_q - 1'b1;
    reopen_cnt_d = reopen_cnt_q;
    nudge_d      = nudge_q;
    case (state_q)
      S_OPEN: begin
        if (alarm || obstruct || open_req) begin
          timer_d = HOLD_LD;
        end else if (close_req || expire) begin
          state_d = S_CLOSING;
          timer_d = TRAVEL_LD;
        end
      end
      S_CLOSING: begin
        if (alarm || open_req) begin
          state_d = S_OPENING;
          timer_d = TRAVEL_LD;
        end else if (obstruct && !nudge_q) begin
          state_d = S_OPENING;
          timer_d = TRAVEL_LD;
          if (reopen_cnt_q != REOPEN_MAX) begin
            reopen_cnt_d = reopen_cnt_q + 1'b1;
          end
          nudge_d = nudge_q | (reopen_cnt_d == REOPEN_MAX);
        end else if (expire) begin
          // Clearing on entry means nudge is already low in the first CLOSED cycle.
          state_d      = S_CLOSED;
          reopen_cnt_d = '0;
          nudge_d      = 1'b0;
        end
      end
      S_CLOSED: begin
        reopen_cnt_d = '0;
        nudge_d      = 1'b0;
        if (!moving && (alarm || open_req)) begin
          state_d = S_OPENING;
          timer_d = TRAVEL_LD;
        end
      end
      S_OPENING: begin
        if (expire) begin
          state_d = S_OPEN;
          timer_d = HOLD_LD;
        end
      end
      default: begin
        state_d = S_OPEN;
        timer_d = HOLD_LD;
      end
    endcase
  end

  assign door_open   = (state_q == S_OPEN);
  assign door_closed = (state_q == S_CLOSED);
  assign motor_open  = (state_q == S_OPENING);
  assign motor_close = (state_q == S_CLOSING);
  assign nudge       = nudge_q;
  assign state       = state_q;

endmodule

// File: doc/elevator_door_ctrl.md
Name: elevator_door_ctrl

Overview:
Parametrised door controller for one elevator car. It is the timed successor to the two-state open/closed door FSM. It adds open-hold and motion timers, reversal on obstruction or call, a close-button shortcut, a motion interlock, and a nudge mode after repeated reopenings. It sits between the call/floor logic (open_req, close_req, moving) and the door motor driver, and supplies door_closed as the travel-permit interlock to the car motion FSM.

Parameters:
HOLD_CYC, 8, cycles the door stays fully open before auto-close (>=1)
TRAVEL_CYC, 4, cycles for a full open or close stroke (>=1)
MAX_REOPEN, 3, obstruction reversals in one close attempt before nudge mode (>=1)
CNT_W, 8, timer width; must hold max(HOLD_CYC, TRAVEL_CYC)-1
RC_W, 2, reopen counter width; must hold MAX_REOPEN

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clock clk
open_req  in  1  open/hold request (car call at this floor, hall call, open button)
close_req  in  1  close-button shortcut
obstruct  in  1  light-curtain/edge sensor, 1 = blocked
alarm  in  1  emergency; forces/keeps door open when car stopped
moving  in  1  car in motion; blocks any opening from CLOSED
door_open  out  1  1 in OPEN
door_closed  out  1  1 in CLOSED; travel permit
motor_open  out  1  1 in OPENING
motor_close  out  1  1 in CLOSING
nudge  out  1  nudge mode active (buzzer, slow close)
state  out  2  OPEN=0, CLOSING=1, CLOSED=2, OPENING=3

Behaviour:
- Moore outputs decoded from registered state; nudge is a register. Exactly one of door_open/door_closed/motor_open/motor_close is 1 in every cycle.
- Reset (async, reset=0): state=OPEN, timer=HOLD_CYC-1, reopen_cnt=0, nudge=0. Outputs at reset: door_open=1, all others 0, state=0. Asserting reset mid-stroke aborts to OPEN immediately.
- Timer: counts down by 1 per cycle while in the state. It is loaded on every state entry: HOLD_CYC-1 for OPEN, TRAVEL_CYC-1 for CLOSING/OPENING. "expire" means timer==0 at a rising edge.
- OPEN:
  - alarm, obstruct or open_req: reload HOLD_CYC-1 and stay.
  - Otherwise, close_req or expire: go to CLOSING.
  - Priority: alarm > obstruct > open_req > close_req > expire.
- CLOSING:
  - alarm, or open_req: go to OPENING; reopen_cnt unchanged.
  - Else obstruct with nudge=0: go to OPENING and reopen_cnt+1. If reopen_cnt+1==MAX_REOPEN, set nudge=1 in the same edge.
  - obstruct with nudge=1: ignored.
  - Else expire: go to CLOSED.
- CLOSED: reopen_cnt<=0, nudge<=0.
  - moving=1: stay; all requests ignored, including alarm.
  - Else alarm or open_req: go to OPENING.
  - close_req and obstruct are ignored.
- OPENING: always completes the stroke. Expire goes to OPEN; requests are ignored. nudge and reopen_cnt are held.
- Full-stroke latencies (defaults): OPEN→CLOSING after 8 idle cycles; CLOSING→CLOSED 4 cycles; OPENING→OPEN 4 cycles.
- HOLD_CYC=1 or TRAVEL_CYC=1: the state lasts exactly one cycle when no hold/reversal condition is present.
- reopen_cnt saturates at MAX_REOPEN and never wraps.
- moving asserted outside CLOSED is a protocol error upstream. The FSM ignores moving there and never drops door_closed=0 on that account.

Test Plan:
1. Release reset, all inputs 0 -> door_open=1 for 8 cycles, motor_close=1 for cycles 9-12, door_closed=1 from cycle 13 and holds.
2. In OPEN at timer=5, pulse close_req 1 cycle -> CLOSING next cycle; then CLOSED 4 cycles later.
3. In OPEN, hold open_req high 20 cycles then release -> door_open stays 1 throughout, CLOSING starts exactly 8 cycles after release.
4. Obstruct pulse during CLOSING 3 times (each reopen/hold/close cycle) -> 3 OPENING reversals; nudge=1 from 3rd reversal edge. Next obstruct during CLOSING is ignored, CLOSED is reached, nudge returns to 0 on CLOSED entry.
5. In CLOSED with moving=1, assert open_req and alarm -> state stays 2. Drop moving with alarm=1 -> OPENING next cycle, then OPEN held while alarm=1.
6. Assert reset low during OPENING mid-stroke -> immediate state=0, door_open=1, nudge=0. After release, normal 8-cycle hold.
